piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
//
// PURPOSE
//   Parallel-in/serial-out transmitter; the sending end of the serial-in/parallel-out
//   shift register link. Accepts an N-bit word via a valid/ready load handshake and
//   shifts it out LSB-first, one bit per clk, with a per-bit valid strobe.
//   Wiring s_out to a SIPO s_in for N shifts leaves the SIPO's parallel output equal
//   to the loaded word.
//
// PARAMETERS
//   N   8   data word width in bits; N >= 2
//
// PORTS
//   clk         in   1   system clock, rising-edge active
//   reset       in   1   asynchronous, active-high reset
//   d_in        in   N   parallel word; sampled only on a load handshake
//   load_valid  in   1   producer has a word on d_in
//   load_ready  out  1   serializer can accept a word this cycle
//   s_out       out  1   serial data, LSB first
//   s_valid     out  1   s_out carries a frame bit this cycle
//   busy        out  1   frame in progress (state SHIFT)
//   done        out  1   one-cycle pulse on the final bit of a frame
//
// BEHAVIOUR
//   - Reset (async, active-high):
//       state=IDLE, shift reg=0, bit count=0
//       s_out=0, s_valid=0, busy=0, done=0, load_ready=1
//       Asserting reset mid-frame aborts the frame immediately; no partial bits resume.
//   - Frame length: F = N bits, or N+1 with the parity option.
//       Bit counter width = $clog2(N+1).
//   - Handshake: a load occurs on a rising edge where load_valid && load_ready.
//       load_valid while load_ready=0 is ignored and not queued.
//   - Loading: d_in is captured into the shift register and the counter clears to 0.
//       After capture, d_in is don't-care.
//   - IDLE: load_ready=1, s_valid=0, busy=0, s_out=0. A load moves the FSM to SHIFT.
//   - SHIFT:
//       s_out = shift_reg[0], s_valid=1, busy=1.
//       Each edge shifts the register right (0 fill) and increments the counter.
//   - Latency: first data bit (d_in[0]) appears the cycle after the load edge.
//       Bit k appears k+1 cycles after the load edge.
//   - Last-bit cycle (count == F-1): done=1 and load_ready=1.
//       Load on that edge: new word is captured, FSM stays in SHIFT, counter=0.
//         Back-to-back frames run with zero gap cycles.
//       No load: FSM returns to IDLE.
//   - load_ready = (state==IDLE) || last-bit cycle. Combinational from state and
//       count only; it never depends on load_valid.
//   - done and load_ready are never asserted outside these cycles.
//
// CONFIGURATION
//   PISO_PARITY_EN defined:
//     - An even-parity bit (^word) is appended after bit N-1. F = N+1.
//     - Parity is computed at load and held in a dedicated flop.
//     - done and load_ready move to the parity cycle.
//   PISO_PARITY_EN undefined:
//     - F = N; no parity logic is synthesized.
//
// TESTING
//   1. Assert reset with clk running -> s_out=0, s_valid=0, busy=0, done=0,
//      load_ready=1. Hold these after release with load_valid=0.
//   2. N=8, load 8'hA5 -> s_out = 1,0,1,0,0,1,0,1 on cycles 1..8; s_valid high for
//      exactly 8 cycles; done only on cycle 8. A SIPO fed by s_out yields Q_out=8'hA5.
//   3. Hold load_valid with 8'h3C then 8'hFF -> 16 contiguous s_valid cycles,
//      no gap. Bits are 0,0,1,1,1,1,0,0 then eight 1s. Two done pulses.
//   4. Mid-frame, pulse load_valid and toggle d_in on bits 0..6 -> ignored.
//      Output stream is unchanged. load_ready=0 until bit 7.
//   5. Assert reset during bit 3 of 8'hF0 -> s_valid=0 and busy=0 immediately.
//      The next load of 8'h81 emits 1,0,0,0,0,0,0,1 cleanly.
//   6. PISO_PARITY_EN: 8'h07 -> 9th bit=1; 8'h03 -> 9th bit=0.
//      done lands on cycle 9; s_valid high for 9 cycles.

Source files
------------

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------------------------
// piso_serializer
//
// Parallel-in / serial-out transmitter. It accepts an N-bit word through a valid/ready load
// handshake and shifts the word out LSB-first, one bit per clock, with a per-bit valid strobe.
// When the frame's final bit is on the wire, a new word can load on that same edge, so
// consecutive frames run with no gap.
//
// Optional feature (compile-time macro PISO_PARITY_EN):
//   When defined, an even-parity bit (XOR of the word) follows bit N-1, so a frame is N+1
//   bits long. When undefined, a frame is N bits and no parity logic is built.
//
// Parameters
//   N           data word width in bits (N >= 2)
//
// Ports
//   clk         in   1  system clock, rising-edge active
//   reset       in   1  asynchronous, active-high reset; aborts any frame in flight
//   d_in        in   N  parallel word, sampled only on a load handshake
//   load_valid  in   1  producer has a word on d_in
//   load_ready  out  1  a word can be accepted this cycle (idle, or on a frame's last bit)
//   s_out       out  1  serial data, LSB first
//   s_valid     out  1  s_out carries a frame bit this cycle
//   busy        out  1  frame in progress
//   done        out  1  one-cycle pulse on the final bit of a frame
// ---------------------------------------------------------------------------------------------
module piso_serializer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         s_out,
    output logic         s_valid,
    output logic         busy,
    output logic         done
);

`ifdef PISO_PARITY_EN
    localparam int unsigned Frame = N + 1;
`else
    localparam int unsigned Frame = N;
`endif
    localparam int unsigned     CntW    = $clog2(N + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(Frame - 1);

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    shreg_q, shreg_d;
    logic [CntW-1:0] count_q, count_d;
`ifdef PISO_PARITY_EN
    logic            parity_q, parity_d;
`endif

    logic last_bit;
    logic load;
    logic s_out_d, s_valid_d, busy_d, done_d;

    // The last-bit cycle is the only point inside a frame where a new word may be taken.
    assign last_bit   = (state_q == StShift) && (count_q == LastCnt);
    assign load_ready = (state_q == StIdle) || last_bit;
    assign load       = load_valid && load_ready;

    // Next-state logic for the FSM, shift register, bit counter and parity flop.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        count_d = count_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        if (load) begin
            state_d = StShift;
            shreg_d = d_in;
            count_d = '0;
`ifdef PISO_PARITY_EN
            parity_d = ^d_in;
`endif
        end else if (state_q == StShift) begin
            shreg_d = shreg_q >> 1;
            if (last_bit) begin
                state_d = StIdle;
                count_d = '0;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end
    end

    // Outputs are registered: derive them from the next state so they line up with it.
    always_comb begin
        busy_d    = (state_d == StShift);
        s_valid_d = busy_d;
        done_d    = busy_d && (count_d == LastCnt);
        s_out_d   = 1'b0;
        if (busy_d) begin
`ifdef PISO_PARITY_EN
            // Data bits are exhausted once the counter reaches N; send the held parity.
            s_out_d = (count_d == CntW'(N)) ? parity_d : shreg_d[0];
`else
            s_out_d = shreg_d[0];
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            count_q <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            count_q <= count_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
            s_out   <= s_out_d;
            s_valid <= s_valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------------------------
// tb_piso_serializer
//
// Scoreboard bench for piso_serializer. The driver issues load handshakes and, for every
// accepted word, queues the expected serial bits. A separate monitor samples the DUT on the
// falling clock edge, pops one expected bit per valid cycle and compares s_out, done, busy
// and load_ready. A small SIPO model rebuilds each word from the stream.
// ---------------------------------------------------------------------------------------------
module tb_piso_serializer;

    localparam int unsigned N = 8;
`ifdef PISO_PARITY_EN
    localparam int unsigned F = N + 1;
`else
    localparam int unsigned F = N;
`endif

    typedef struct packed {
        logic         bit_val;
        logic         last;
        logic         par;
        logic [N-1:0] word;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         load_valid = 1'b0;
    logic [N-1:0] d_in = '0;
    logic         load_ready;
    logic         s_out;
    logic         s_valid;
    logic         busy;
    logic         done;

    exp_t         q[$];
    exp_t         e;
    logic [N-1:0] sipo = '0;
    int           errors = 0;
    int           checks = 0;

    always #5 clk = ~clk;

    piso_serializer #(
        .N(N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .d_in       (d_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .s_out      (s_out),
        .s_valid    (s_valid),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Expected frame: word bits LSB first, then the parity bit when enabled.
    task automatic push_frame(input logic [N-1:0] w);
        for (int i = 0; i < int'(N); i++) begin
            q.push_back('{bit_val: w[i], last: (i == int'(F) - 1), par: 1'b0, word: w});
        end
`ifdef PISO_PARITY_EN
        q.push_back('{bit_val: ^w, last: 1'b1, par: 1'b1, word: w});
`endif
    endtask

    // Called at posedge+1. Holds load_valid until a handshake edge, bounded by a cycle budget.
    task automatic send_word(input logic [N-1:0] w);
        bit accepted;
        bit rdy;
        accepted   = 1'b0;
        d_in       = w;
        load_valid = 1'b1;
        for (int c = 0; c < 40 && !accepted; c++) begin
            rdy = load_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                accepted = 1'b1;
                push_frame(w);
            end
        end
        load_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL load_accept: got no handshake required handshake for %0h", w);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: one comparison set per falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                check("idle_s_valid", s_valid, 0);
                check("idle_busy", busy, 0);
                check("idle_done", done, 0);
                check("idle_s_out", s_out, 0);
                check("idle_load_ready", load_ready, 1);
            end else begin
                e = q.pop_front();
                check("bit_s_valid", s_valid, 1);
                check("bit_busy", busy, 1);
                check("bit_s_out", s_out, e.bit_val);
                check("bit_done", done, e.last);
                check("bit_load_ready", load_ready, e.last);
                if (!e.par) sipo = {s_out, sipo[N-1:1]};
                if (e.last) check("sipo_word", sipo, e.word);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with the clock running, then hold idle with load_valid low.
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        idle(3);

        // Single frame: A5 -> 1,0,1,0,0,1,0,1.
        send_word(8'hA5);
        idle(F + 2);

        // Back-to-back: 3C then FF with no gap.
        send_word(8'h3C);
        send_word(8'hFF);
        idle(F + 2);

        // Mid-frame load attempts are ignored while load_ready is low.
        send_word(8'h5A);
        for (int k = 0; k < 7; k++) begin
            load_valid = (k % 2 == 0);
            d_in       = ~d_in;
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        idle(3);

        // Reset during bit 3 of F0 aborts the frame at once.
        send_word(8'hF0);
        idle(3);
        #1 reset = 1'b1;
        q.delete();
        #1;
        check("abort_s_valid", s_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_load_ready", load_ready, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle(1);
        send_word(8'h81);
        idle(F + 2);

        // Parity vectors: 07 has odd weight (parity 1), 03 even weight (parity 0).
        send_word(8'h07);
        idle(F + 2);
        send_word(8'h03);

        for (int c = 0; c < 50 && q.size() != 0; c++) @(posedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending bits required 0", q.size());
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
